// File: rtl/mc_control_pkg.sv
// Shared types and constants for the multi-cycle MIPS control unit.
// Optional illegal-instruction trap: MC_CONTROL_ILLEGAL_TRAP_EN.
package mc_control_pkg;

   typedef enum logic [3:0] {
      StIdle   = 4'd0,
      StFetch  = 4'd1,
      StDecode = 4'd2,
      StExecR  = 4'd3,
      StWbR    = 4'd4,
      StExecI  = 4'd5,
      StWbI    = 4'd6,
      StMemAdr = 4'd7,
      StMemRd  = 4'd8,
      StWbMem  = 4'd9,
      StMemWr  = 4'd10,
      StBranch = 4'd11,
      StJump   = 4'd12,
      StTrap   = 4'd13
   } state_e;

   localparam logic [5:0] OpRtype = 6'h00;
   localparam logic [5:0] OpAddi  = 6'h08;
   localparam logic [5:0] OpLw    = 6'h23;
   localparam logic [5:0] OpSw    = 6'h2B;
   localparam logic [5:0] OpBeq   = 6'h04;
   localparam logic [5:0] OpBne   = 6'h05;
   localparam logic [5:0] OpJ     = 6'h02;

   localparam logic [5:0] FnAdd = 6'h20;
   localparam logic [5:0] FnSub = 6'h22;
   localparam logic [5:0] FnAnd = 6'h24;
   localparam logic [5:0] FnOr  = 6'h25;
   localparam logic [5:0] FnSlt = 6'h2A;

   localparam logic [3:0] AluAdd = 4'b0010;
   localparam logic [3:0] AluSub = 4'b0110;
   localparam logic [3:0] AluAnd = 4'b0000;
   localparam logic [3:0] AluOr  = 4'b0001;
   localparam logic [3:0] AluSlt = 4'b0111;

   typedef enum logic [1:0] {
      AluOpAdd   = 2'b00,
      AluOpSub   = 2'b01,
      AluOpFunct = 2'b10
   } alu_op_e;

   // *_rdy / *_br fields are qualified by mem_ready / zero outside the register.
   typedef struct packed {
      logic       pc_en;
      logic       pc_en_rdy;
      logic       pc_en_br;
      logic [1:0] pc_src;
      logic       iord;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write_rdy;
      logic       reg_dst;
      logic       reg_write;
      logic       mem_to_reg;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic       alu_en;
      alu_op_e    alu_op;
      logic       done;
      logic       done_rdy;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      logic       illegal;
`endif
   } ctrl_t;

   function automatic logic op_known(input logic [5:0] op);
      return op inside {OpRtype, OpAddi, OpLw, OpSw, OpBeq, OpBne, OpJ};
   endfunction

   function automatic logic funct_known(input logic [5:0] fn);
      return fn inside {FnAdd, FnSub, FnAnd, FnOr, FnSlt};
   endfunction

   function automatic ctrl_t state_ctrl(input state_e st);
      ctrl_t c;
      c = '0;
      case (st)
         StFetch: begin
            c.pc_en_rdy    = 1'b1;
            c.mem_read     = 1'b1;
            c.ir_write_rdy = 1'b1;
            c.alu_src_b    = 2'b01;
            c.alu_en       = 1'b1;
         end
         StDecode: begin
            c.alu_src_b = 2'b11;
            c.alu_en    = 1'b1;
         end
         StExecR: begin
            c.alu_src_a = 1'b1;
            c.alu_en    = 1'b1;
            c.alu_op    = AluOpFunct;
         end
         StWbR: begin
            c.reg_dst   = 1'b1;
            c.reg_write = 1'b1;
            c.done      = 1'b1;
         end
         StExecI, StMemAdr: begin
            c.alu_src_a = 1'b1;
            c.alu_src_b = 2'b10;
            c.alu_en    = 1'b1;
         end
         StWbI: begin
            c.reg_write = 1'b1;
            c.done      = 1'b1;
         end
         StMemRd: begin
            c.iord     = 1'b1;
            c.mem_read = 1'b1;
         end
         StWbMem: begin
            c.mem_to_reg = 1'b1;
            c.reg_write  = 1'b1;
            c.done       = 1'b1;
         end
         StMemWr: begin
            c.iord      = 1'b1;
            c.mem_write = 1'b1;
            c.done_rdy  = 1'b1;
         end
         StBranch: begin
            c.pc_en_br  = 1'b1;
            c.pc_src    = 2'b01;
            c.alu_src_a = 1'b1;
            c.alu_en    = 1'b1;
            c.alu_op    = AluOpSub;
            c.done      = 1'b1;
         end
         StJump: begin
            c.pc_en  = 1'b1;
            c.pc_src = 2'b10;
            c.done   = 1'b1;
         end
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
         StTrap: c.illegal = 1'b1;
`endif
         default: ;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// ALU operation decode from alu_op and R-type funct; shared with the single-cycle path.
// Unaffected by MC_CONTROL_ILLEGAL_TRAP_EN: unknown funct always decodes as add.
module alu_ctrl_decode
   import mc_control_pkg::*;
#(
   parameter int unsigned FUNCT_W    = 6,
   parameter int unsigned ALU_CTRL_W = 4
) (
   input  alu_op_e               alu_op_i,
   input  logic [FUNCT_W-1:0]    funct_i,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_o
);

   logic [3:0] code;

   always_comb begin
      code = AluAdd;
      case (alu_op_i)
         AluOpSub: code = AluSub;
         AluOpFunct: begin
            case (6'(funct_i))
               FnSub:   code = AluSub;
               FnAnd:   code = AluAnd;
               FnOr:    code = AluOr;
               FnSlt:   code = AluSlt;
               default: code = AluAdd;
            endcase
         end
         default: code = AluAdd;
      endcase
      alu_ctrl_o = ALU_CTRL_W'(code);
   end

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS control FSM with a timed-out memory handshake.
// Define MC_CONTROL_ILLEGAL_TRAP_EN to trap unknown opcodes/functs and expose illegal_op_o.
module mc_control
   import mc_control_pkg::*;
#(
   parameter int unsigned ALU_CTRL_W  = 4,
   parameter int unsigned FUNCT_W     = 6,
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic [5:0]            opcode_i,
   input  logic [FUNCT_W-1:0]    funct_i,
   input  logic                  zero_i,
   input  logic                  mem_ready_i,
   output logic                  pc_en_o,
   output logic [1:0]            pc_src_o,
   output logic                  iord_o,
   output logic                  mem_read_o,
   output logic                  mem_write_o,
   output logic                  ir_write_o,
   output logic                  reg_dst_o,
   output logic                  reg_write_o,
   output logic                  mem_to_reg_o,
   output logic                  alu_src_a_o,
   output logic [1:0]            alu_src_b_o,
   output logic [ALU_CTRL_W-1:0] alu_ctrl_o,
   output logic                  instr_done_o,
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
   output logic                  illegal_op_o,
`endif
   output logic                  mem_timeout_o
);

   localparam int unsigned CntW = $clog2(MEM_TIMEOUT + 1);

   state_e                state_q, state_d;
   ctrl_t                 ctrl_q;
   logic [CntW-1:0]       cnt_q, cnt_d;
   logic                  wait_st, abort, known_op;
   logic [ALU_CTRL_W-1:0] alu_ctrl_raw;

   always_comb begin
      wait_st  = state_q inside {StFetch, StMemRd, StMemWr};
      // Ready on the limit cycle wins over the abort.
      abort    = wait_st && !mem_ready_i && (cnt_q == CntW'(MEM_TIMEOUT));
      known_op = op_known(opcode_i);

      state_d = state_q;
      case (state_q)
         StIdle:  state_d = StFetch;
         StFetch: if (mem_ready_i) state_d = StDecode;
         StDecode: begin
            case (opcode_i)
               OpRtype:     state_d = StExecR;
               OpAddi:      state_d = StExecI;
               OpLw, OpSw:  state_d = StMemAdr;
               OpBeq, OpBne: state_d = StBranch;
               OpJ:         state_d = StJump;
               default:     state_d = StFetch;
            endcase
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
            if (!known_op || (opcode_i == OpRtype && !funct_known(6'(funct_i)))) begin
               state_d = StTrap;
            end
`endif
         end
         StExecR:  state_d = StWbR;
         StExecI:  state_d = StWbI;
         StMemAdr: state_d = (opcode_i == OpLw) ? StMemRd : StMemWr;
         StMemRd: begin
            if (mem_ready_i) state_d = StWbMem;
            else if (abort)  state_d = StFetch;
         end
         StMemWr:  if (mem_ready_i || abort) state_d = StFetch;
         StTrap:   state_d = StTrap;
         default:  state_d = StFetch;
      endcase

      // Any state change (or an abort back into FETCH) starts a fresh wait window.
      cnt_d = cnt_q;
      if ((state_d != state_q) || abort) begin
         cnt_d = '0;
      end else if (wait_st && !mem_ready_i) begin
         cnt_d = cnt_q + CntW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= StIdle;
         ctrl_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= state_ctrl(state_d);
         cnt_q   <= cnt_d;
      end
   end

   alu_ctrl_decode #(
      .FUNCT_W    (FUNCT_W),
      .ALU_CTRL_W (ALU_CTRL_W)
   ) u_alu_ctrl_decode (
      .alu_op_i   (ctrl_q.alu_op),
      .funct_i    (funct_i),
      .alu_ctrl_o (alu_ctrl_raw)
   );

   // opcode_i[0] separates BNE (1) from BEQ (0).
   assign pc_en_o       = ctrl_q.pc_en
                        | (ctrl_q.pc_en_rdy & mem_ready_i)
                        | (ctrl_q.pc_en_br & (zero_i ^ opcode_i[0]));
   assign pc_src_o      = ctrl_q.pc_src;
   assign iord_o        = ctrl_q.iord;
   assign mem_read_o    = ctrl_q.mem_read;
   assign mem_write_o   = ctrl_q.mem_write;
   assign ir_write_o    = ctrl_q.ir_write_rdy & mem_ready_i;
   assign reg_dst_o     = ctrl_q.reg_dst;
   assign reg_write_o   = ctrl_q.reg_write;
   assign mem_to_reg_o  = ctrl_q.mem_to_reg;
   assign alu_src_a_o   = ctrl_q.alu_src_a;
   assign alu_src_b_o   = ctrl_q.alu_src_b;
   assign alu_ctrl_o    = ctrl_q.alu_en ? alu_ctrl_raw : '0;
   assign mem_timeout_o = abort;

`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
   assign illegal_op_o  = ctrl_q.illegal;
   assign instr_done_o  = ctrl_q.done | (ctrl_q.done_rdy & mem_ready_i);
`else
   assign instr_done_o  = ctrl_q.done | (ctrl_q.done_rdy & mem_ready_i)
                        | ((state_q == StDecode) & !known_op);
`endif

endmodule

// File: tb/tb_mc_control.sv
// Directed self-checking bench for mc_control; honours MC_CONTROL_ILLEGAL_TRAP_EN.
module tb_mc_control;

   localparam int T     = 16;
   localparam int A_ADD = 2;
   localparam int A_SUB = 6;
   localparam int A_SLT = 7;

   logic       clk_i = 1'b0;
   logic       rst_ni;
   logic [5:0] opcode_i;
   logic [5:0] funct_i;
   logic       zero_i;
   logic       mem_ready_i;
   logic       pc_en, iord, mem_read, mem_write, ir_write, reg_dst, reg_write;
   logic       mem_to_reg, alu_src_a, instr_done, mem_timeout;
   logic [1:0] pc_src, alu_src_b;
   logic [3:0] alu_ctrl;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
   logic       illegal_op;
`endif

   mc_control #(
      .ALU_CTRL_W  (4),
      .FUNCT_W     (6),
      .MEM_TIMEOUT (T)
   ) dut (
      .clk_i         (clk_i),
      .rst_ni        (rst_ni),
      .opcode_i      (opcode_i),
      .funct_i       (funct_i),
      .zero_i        (zero_i),
      .mem_ready_i   (mem_ready_i),
      .pc_en_o       (pc_en),
      .pc_src_o      (pc_src),
      .iord_o        (iord),
      .mem_read_o    (mem_read),
      .mem_write_o   (mem_write),
      .ir_write_o    (ir_write),
      .reg_dst_o     (reg_dst),
      .reg_write_o   (reg_write),
      .mem_to_reg_o  (mem_to_reg),
      .alu_src_a_o   (alu_src_a),
      .alu_src_b_o   (alu_src_b),
      .alu_ctrl_o    (alu_ctrl),
      .instr_done_o  (instr_done),
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      .illegal_op_o  (illegal_op),
`endif
      .mem_timeout_o (mem_timeout)
   );

   always #5 clk_i = ~clk_i;

   logic [31:0] obs;
   assign obs = {13'd0, pc_en, pc_src, iord, mem_read, mem_write, ir_write, reg_dst, reg_write,
                 mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, instr_done, mem_timeout};

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   function automatic logic [31:0] vec(int pe, int ps, int io, int mr, int mw, int irw, int rd,
                                       int rw, int m2r, int asa, int asb, int alu, int dn,
                                       int to);
      return {13'd0, pe[0], ps[1:0], io[0], mr[0], mw[0], irw[0], rd[0], rw[0], m2r[0],
              asa[0], asb[1:0], alu[3:0], dn[0], to[0]};
   endfunction

   logic [31:0] e_fetch, e_decode, e_exr_add, e_exr_slt, e_exr_sub, e_wbr, e_memadr, e_memrd;
   logic [31:0] e_wbmem, e_br_taken, e_br_not, e_jump, e_memwr, e_memwr_done, e_memwr_to;
   logic [31:0] e_nop_dec;

   task automatic cyc(input logic rdy);
      @(negedge clk_i);
      mem_ready_i = rdy;
      #1;
   endtask

   task automatic fetch_decode(input string tag, input logic [5:0] op, input logic [5:0] fn);
      cyc(1'b1);
      check({tag, "_fetch"}, obs, e_fetch);
      opcode_i = op;
      funct_i  = fn;
      cyc(1'b1);
      check({tag, "_decode"}, obs, e_decode);
   endtask

   int rw_cnt;
   int m2r_cnt;
   int done_cnt;
   int to_cnt;

   initial begin
      //                pe ps io mr mw ir rd rw m2 sa sb alu     dn to
      e_fetch      = vec(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 1, A_ADD, 0, 0);
      e_decode     = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 0, 0);
      e_exr_add    = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_ADD, 0, 0);
      e_exr_slt    = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SLT, 0, 0);
      e_exr_sub    = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 0, 0);
      e_wbr        = vec(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0,     1, 0);
      e_memadr     = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 2, A_ADD, 0, 0);
      e_memrd      = vec(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0);
      e_wbmem      = vec(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0,     1, 0);
      e_br_taken   = vec(1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 1, 0);
      e_br_not     = vec(0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, A_SUB, 1, 0);
      e_jump       = vec(1, 2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,     1, 0);
      e_memwr      = vec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 0);
      e_memwr_done = vec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,     1, 0);
      e_memwr_to   = vec(0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0, 0,     0, 1);
      e_nop_dec    = vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 3, A_ADD, 1, 0);

      rst_ni      = 1'b0;
      mem_ready_i = 1'b1;
      opcode_i    = 6'h00;
      funct_i     = 6'h20;
      zero_i      = 1'b0;

      repeat (3) begin
         @(negedge clk_i);
         #1;
         check("reset_outputs", obs, 32'd0);
      end
      rst_ni = 1'b1;

      // ADD then SLT: FETCH, DECODE, EXEC_R, WB_R
      fetch_decode("add", 6'h00, 6'h20);
      cyc(1'b1); check("add_exec", obs, e_exr_add);
      cyc(1'b1); check("add_wb", obs, e_wbr);
      fetch_decode("slt", 6'h00, 6'h2A);
      cyc(1'b1); check("slt_exec", obs, e_exr_slt);
      cyc(1'b1); check("slt_wb", obs, e_wbr);

      // LW with three wait cycles in MEM_RD: 8 cycles in total
      fetch_decode("lw", 6'h23, 6'h00);
      cyc(1'b1); check("lw_memadr", obs, e_memadr);
      rw_cnt  = 0;
      m2r_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0); check("lw_memrd_wait", obs, e_memrd);
         rw_cnt += int'(reg_write);
      end
      cyc(1'b1); check("lw_memrd_ready", obs, e_memrd);
      rw_cnt += int'(reg_write);
      cyc(1'b1); check("lw_wbmem", obs, e_wbmem);
      rw_cnt  += int'(reg_write);
      m2r_cnt += int'(reg_write & mem_to_reg);
      check("lw_reg_write_count", rw_cnt, 1);
      check("lw_mem_to_reg_write", m2r_cnt, 1);

      // Branches and jump
      zero_i = 1'b1;
      fetch_decode("beq", 6'h04, 6'h00);
      cyc(1'b1); check("beq_taken", obs, e_br_taken);
      fetch_decode("bne", 6'h05, 6'h00);
      cyc(1'b1); check("bne_not_taken", obs, e_br_not);
      zero_i = 1'b0;
      fetch_decode("j", 6'h02, 6'h00);
      cyc(1'b1); check("jump", obs, e_jump);

      // SW timeout: T non-ready cycles bring the counter to the limit, the next aborts
      fetch_decode("sw_to", 6'h2B, 6'h00);
      cyc(1'b1); check("sw_to_memadr", obs, e_memadr);
      done_cnt = 0;
      to_cnt   = 0;
      for (int k = 0; k < T; k++) begin
         cyc(1'b0); check("sw_to_wait", obs, e_memwr);
         done_cnt += int'(instr_done);
      end
      cyc(1'b0); check("sw_to_abort", obs, e_memwr_to);
      done_cnt += int'(instr_done);
      cyc(1'b1); check("sw_to_refetch", obs, e_fetch);
      check("sw_to_no_done", done_cnt, 0);

      // SW with ready arriving exactly on the limit cycle completes normally
      cyc(1'b1); check("sw_lim_decode", obs, e_decode);
      cyc(1'b1); check("sw_lim_memadr", obs, e_memadr);
      for (int k = 0; k < T; k++) begin
         cyc(1'b0);
         to_cnt += int'(mem_timeout);
      end
      cyc(1'b1); check("sw_lim_done", obs, e_memwr_done);
      check("sw_lim_no_timeout", to_cnt, 0);

      // Unknown opcode 0x3F
      fetch_decode("prep_ill", 6'h00, 6'h20);
      cyc(1'b1); check("prep_ill_exec", obs, e_exr_add);
      cyc(1'b1); check("prep_ill_wb", obs, e_wbr);
      cyc(1'b1); check("ill_fetch", obs, e_fetch);
      opcode_i = 6'h3F;
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      cyc(1'b1); check("ill_decode", obs, e_decode);
      check("ill_decode_flag", 32'(illegal_op), 32'd0);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1);
         check("trap_quiet", obs, 32'd0);
         check("trap_flag", 32'(illegal_op), 32'd1);
      end
`else
      cyc(1'b1); check("nop_decode", obs, e_nop_dec);
      cyc(1'b1); check("nop_refetch", obs, e_fetch);
`endif

      // Asynchronous reset drops outputs without waiting for an edge
      #1 rst_ni = 1'b0;
      #1 check("rst_async", obs, 32'd0);
`ifdef MC_CONTROL_ILLEGAL_TRAP_EN
      check("rst_async_flag", 32'(illegal_op), 32'd0);
`endif
      @(negedge clk_i);
      rst_ni = 1'b1;

      fetch_decode("sub", 6'h00, 6'h22);
      cyc(1'b1); check("sub_exec", obs, e_exr_sub);
      #1 rst_ni = 1'b0;
      #1 check("rst_mid_exec", obs, 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
